// File: rtl/adc_acq_pkg.sv
// Shared types, constants and frame-length helper for the ADC capture sequencer.
package adc_acq_pkg;

  localparam int CNT_W         = 16;
  localparam int DEF_BURST_LEN = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_t;

  // Frame length rounded down to whole bursts, never below one burst.
  function automatic logic [CNT_W-1:0] calc_frame_len(
    input logic [CNT_W-1:0] frame_len,
    input logic [CNT_W-1:0] num_samples,
    input logic [CNT_W-1:0] burst_len
  );
    logic [CNT_W-1:0] len;
    logic [CNT_W-1:0] mask;
    len  = (frame_len == '0) ? num_samples : frame_len;
    mask = burst_len - CNT_W'(1);
    len  = len & ~mask;
    if (len == '0) begin
      len = burst_len;
    end
    return len;
  endfunction

endpackage

// File: rtl/acq_burst_tracker.sv
// Pending/outstanding DDR burst bookkeeping; requests the DMA while any burst is ready.
module acq_burst_tracker
  import adc_acq_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic ack_i,
  input  logic done_i,
  input  logic clear_i,
  output logic burst_req_o,
  output logic idle_o
);

  logic [CNT_W-1:0] pend_q, pend_d;
  logic [CNT_W-1:0] outs_q, outs_d;
  logic             req_q, req_d;
  logic             ack_ok;
  logic             done_ok;

  // Acks and completions with nothing to account against are dropped.
  assign ack_ok  = ack_i && (pend_q != '0);
  assign done_ok = done_i && (outs_q != '0);

  always_comb begin
    pend_d = pend_q;
    outs_d = outs_q;
    if (clear_i) begin
      pend_d = '0;
      outs_d = '0;
    end else begin
      if (inc_i && !ack_ok) begin
        pend_d = pend_q + CNT_W'(1);
      end else if (!inc_i && ack_ok) begin
        pend_d = pend_q - CNT_W'(1);
      end
      if (ack_ok && !done_ok) begin
        outs_d = outs_q + CNT_W'(1);
      end else if (!ack_ok && done_ok) begin
        outs_d = outs_q - CNT_W'(1);
      end
    end
    req_d = (pend_d != '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q <= '0;
      outs_q <= '0;
      req_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      outs_q <= outs_d;
      req_q  <= req_d;
    end
  end

  assign burst_req_o = req_q;
  assign idle_o      = (pend_q == '0) && (outs_q == '0);

endmodule

// File: rtl/adc_capture_sequencer.sv
// Frame sequencer: gates decimated ADC samples into the FIFO for one frame and
// hands completed bursts to the DDR writer, signalling when the frame has landed.
module adc_capture_sequencer
  import adc_acq_pkg::*;
#(
  parameter int DATA_WIDTH     = 12,
  parameter int NUMBER_SAMPLES = 1024,
  parameter int BURST_LEN      = DEF_BURST_LEN
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Start,
  input  logic                  Abort,
  input  logic                  Continuous,
  input  logic [15:0]           Frame_Len,
  input  logic                  Acq_Valid,
  input  logic [DATA_WIDTH-1:0] ADC_Data,
  input  logic                  FIFO_Full,
  output logic                  FIFO_Wr_En,
  output logic [DATA_WIDTH-1:0] FIFO_Din,
  output logic                  Burst_Req,
  input  logic                  Burst_Ack,
  input  logic                  Burst_Done,
  output logic                  Busy,
  output logic                  Frame_Done,
  output logic                  Overflow,
  output logic [15:0]           Drop_Cnt,
  output logic [15:0]           Sample_Cnt
);

  localparam logic [CNT_W-1:0] NUM_SAMP_C  = CNT_W'(NUMBER_SAMPLES);
  localparam logic [CNT_W-1:0] BURST_LEN_C = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] BURST_MASK  = CNT_W'(BURST_LEN - 1);

  cap_state_t            state_q, state_d;
  logic [CNT_W-1:0]      len_q, len_d;
  logic [CNT_W-1:0]      sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0]      drop_cnt_q, drop_cnt_d;
  logic                  overflow_q, overflow_d;
  logic                  wr_en_q, wr_en_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  burst_inc_q, burst_inc_d;
  logic                  busy_q, busy_d;
  logic                  frame_done_q, frame_done_d;

  logic [CNT_W-1:0]      sample_cnt_nxt;
  logic                  accept;
  logic                  drop;
  logic                  start_evt;
  logic                  rearm;
  logic                  trk_clear;
  logic                  trk_idle;

  assign sample_cnt_nxt = sample_cnt_q + CNT_W'(1);
  assign accept    = (state_q == ST_CAPTURE) && Acq_Valid && !FIFO_Full && !Abort;
  assign drop      = (state_q == ST_CAPTURE) && Acq_Valid && FIFO_Full && !Abort;
  assign start_evt = (state_q == ST_IDLE) && Start && !Abort;
  assign rearm     = (state_q == ST_DONE) && Continuous && !Abort;
  assign trk_clear = Abort || start_evt;

  // The burst increment lags the write by a cycle so Burst_Req follows the FIFO strobe.
  acq_burst_tracker u_tracker (
    .clk_i       (Clk),
    .rst_i       (Rst),
    .inc_i       (burst_inc_q),
    .ack_i       (Burst_Ack),
    .done_i      (Burst_Done),
    .clear_i     (trk_clear),
    .burst_req_o (Burst_Req),
    .idle_o      (trk_idle)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (Abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Start) state_d = ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (accept && (sample_cnt_nxt == len_q)) state_d = ST_FLUSH;
        end
        ST_FLUSH: begin
          // A burst still in the increment register is not yet visible to the tracker.
          if (trk_idle && !burst_inc_q) state_d = ST_DONE;
        end
        ST_DONE: begin
          state_d = Continuous ? ST_CAPTURE : ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    wr_en_d      = accept;
    din_d        = accept ? ADC_Data : din_q;
    burst_inc_d  = accept && ((sample_cnt_nxt & BURST_MASK) == '0);
    len_d        = (start_evt || rearm) ? calc_frame_len(Frame_Len, NUM_SAMP_C, BURST_LEN_C)
                                        : len_q;
    sample_cnt_d = sample_cnt_q;
    if (Abort || start_evt || rearm) begin
      sample_cnt_d = '0;
    end else if (accept) begin
      sample_cnt_d = sample_cnt_nxt;
    end
    // Drop accounting spans the whole capture, including continuous re-arms.
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (start_evt) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
    busy_d       = (state_d != ST_IDLE);
    frame_done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      len_q        <= '0;
      sample_cnt_q <= '0;
      drop_cnt_q   <= '0;
      overflow_q   <= 1'b0;
      wr_en_q      <= 1'b0;
      din_q        <= '0;
      burst_inc_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      len_q        <= len_d;
      sample_cnt_q <= sample_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      overflow_q   <= overflow_d;
      wr_en_q      <= wr_en_d;
      din_q        <= din_d;
      burst_inc_q  <= burst_inc_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign FIFO_Wr_En = wr_en_q;
  assign FIFO_Din   = din_q;
  assign Busy       = busy_q;
  assign Frame_Done = frame_done_q;
  assign Overflow   = overflow_q;
  assign Drop_Cnt   = drop_cnt_q;
  assign Sample_Cnt = sample_cnt_q;

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Randomized bench for adc_capture_sequencer against a transaction-level frame model.
module tb_adc_capture_sequencer;

  localparam int DW = 12;
  localparam int NS = 1024;
  localparam int BL = 16;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          Start, Abort, Continuous;
  logic [15:0]   Frame_Len;
  logic          Acq_Valid;
  logic [DW-1:0] ADC_Data;
  logic          FIFO_Full;
  logic          FIFO_Wr_En;
  logic [DW-1:0] FIFO_Din;
  logic          Burst_Req, Burst_Ack, Burst_Done;
  logic          Busy, Frame_Done, Overflow;
  logic [15:0]   Drop_Cnt, Sample_Cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model: frame phase 0 idle, 1 capturing, 2 draining, 3 frame complete.
  int            m_mode, m_len, m_cnt, m_drop, m_pend, m_outs, m_new_bursts;
  bit            m_ovf, m_wr;
  logic [DW-1:0] m_din;

  int wr_seen, fd_seen, dma_mode;

  always #5 Clk = ~Clk;

  adc_capture_sequencer #(
    .DATA_WIDTH     (DW),
    .NUMBER_SAMPLES (NS),
    .BURST_LEN      (BL)
  ) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Start      (Start),
    .Abort      (Abort),
    .Continuous (Continuous),
    .Frame_Len  (Frame_Len),
    .Acq_Valid  (Acq_Valid),
    .ADC_Data   (ADC_Data),
    .FIFO_Full  (FIFO_Full),
    .FIFO_Wr_En (FIFO_Wr_En),
    .FIFO_Din   (FIFO_Din),
    .Burst_Req  (Burst_Req),
    .Burst_Ack  (Burst_Ack),
    .Burst_Done (Burst_Done),
    .Busy       (Busy),
    .Frame_Done (Frame_Done),
    .Overflow   (Overflow),
    .Drop_Cnt   (Drop_Cnt),
    .Sample_Cnt (Sample_Cnt)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int eff_len(input int flen);
    int base;
    int r;
    base = (flen == 0) ? NS : flen;
    r    = (base / BL) * BL;
    if (r == 0) r = BL;
    return r;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_len = 0; m_cnt = 0; m_drop = 0;
    m_pend = 0; m_outs = 0; m_new_bursts = 0;
    m_ovf = 0; m_wr = 0; m_din = '0;
  endtask

  task automatic model_edge();
    bit ack_ok, done_ok, quiet;
    int pend_n, outs_n;
    ack_ok  = Burst_Ack && (m_pend > 0);
    done_ok = Burst_Done && (m_outs > 0);
    quiet   = (m_pend == 0) && (m_outs == 0) && (m_new_bursts == 0);
    pend_n  = m_pend + m_new_bursts - int'(ack_ok);
    outs_n  = m_outs + int'(ack_ok) - int'(done_ok);
    m_new_bursts = 0;
    m_wr = 0;
    if (Abort) begin
      m_mode = 0; m_cnt = 0; pend_n = 0; outs_n = 0;
    end else begin
      case (m_mode)
        0: if (Start) begin
          m_mode = 1; m_len = eff_len(int'(Frame_Len)); m_cnt = 0;
          m_drop = 0; m_ovf = 0; pend_n = 0; outs_n = 0;
        end
        1: if (Acq_Valid) begin
          if (!FIFO_Full) begin
            m_wr = 1; m_din = ADC_Data; m_cnt++;
            if (m_cnt % BL == 0) m_new_bursts = 1;
            if (m_cnt == m_len) m_mode = 2;
          end else begin
            if (m_drop < 65535) m_drop++;
            m_ovf = 1;
          end
        end
        2: if (quiet) m_mode = 3;
        default: begin
          if (Continuous) begin
            m_mode = 1; m_len = eff_len(int'(Frame_Len)); m_cnt = 0;
          end else begin
            m_mode = 0;
          end
        end
      endcase
    end
    m_pend = pend_n;
    m_outs = outs_n;
  endtask

  task automatic compare();
    check_val("wr_en", 32'(FIFO_Wr_En), 32'(m_wr));
    if (m_wr) check_val("din", 32'(FIFO_Din), 32'(m_din));
    check_val("burst_req", 32'(Burst_Req), 32'(m_pend > 0));
    check_val("busy", 32'(Busy), 32'(m_mode != 0));
    check_val("frame_done", 32'(Frame_Done), 32'(m_mode == 3));
    check_val("sample_cnt", 32'(Sample_Cnt), 32'(m_cnt));
    check_val("drop_cnt", 32'(Drop_Cnt), 32'(m_drop));
    check_val("overflow", 32'(Overflow), 32'(m_ovf));
  endtask

  task automatic step();
    @(posedge Clk);
    model_edge();
    #1;
    compare();
    if (FIFO_Wr_En) wr_seen++;
    if (Frame_Done) fd_seen++;
    Start = 1'b0;
    Abort = 1'b0;
    case (dma_mode)
      0: begin
        Burst_Ack  = Burst_Req && ($urandom_range(0, 2) == 0);
        Burst_Done = ($urandom_range(0, 3) == 0);
      end
      1: begin
        Burst_Ack  = Burst_Req && ($urandom_range(0, 2) == 0);
        Burst_Done = 1'b0;
      end
      2: begin
        Burst_Ack  = 1'b0;
        Burst_Done = 1'b0;
      end
      default: begin
        Burst_Ack  = ($urandom_range(0, 2) == 0);
        Burst_Done = ($urandom_range(0, 3) == 0);
      end
    endcase
    ADC_Data = DW'($urandom);
  endtask

  task automatic start_capture(input int flen, input bit cont);
    Frame_Len  = 16'(flen);
    Continuous = cont;
    Start      = 1'b1;
    Acq_Valid  = 1'b0;
    step();
    wr_seen = 0;
    fd_seen = 0;
  endtask

  task automatic run_frame(input int period, input int drop_at, input int drop_n,
                           input int stop_cont_after, input int budget);
    int k;
    int drops_left;
    bit fin;
    k = 0; drops_left = drop_n; fin = 0;
    while (!fin) begin
      Acq_Valid = ((k % period) == 0);
      FIFO_Full = Acq_Valid && (drops_left > 0) && (wr_seen >= drop_at);
      if (FIFO_Full) drops_left--;
      step();
      k++;
      if (fd_seen >= stop_cont_after) Continuous = 1'b0;
      if (!Busy) begin
        fin = 1;
      end else if (k >= budget) begin
        check_val("timeout_frame", 0, 1);
        fin = 1;
      end
    end
    Acq_Valid = 1'b0;
    FIFO_Full = 1'b0;
  endtask

  initial begin
    int k;
    int lens[3];
    int exps[3];
    Rst = 1'b1; Start = 0; Abort = 0; Continuous = 0; Frame_Len = '0;
    Acq_Valid = 0; ADC_Data = '0; FIFO_Full = 0; Burst_Ack = 0; Burst_Done = 0;
    dma_mode = 2; wr_seen = 0; fd_seen = 0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    compare();
    check_val("rst_din", 32'(FIFO_Din), 0);
    Rst = 1'b0;

    // Basic frame with a strobe every third cycle.
    dma_mode = 0;
    start_capture(64, 0);
    run_frame(3, 0, 0, 1000, 2000);
    check_val("basic_writes", wr_seen, 64);
    check_val("basic_frames", fd_seen, 1);

    // Frame length rounding.
    lens = '{0, 37, 5};
    exps = '{1024, 32, 16};
    for (int i = 0; i < 3; i++) begin
      start_capture(lens[i], 0);
      run_frame(1, 0, 0, 1000, 3000);
      check_val("len_writes", wr_seen, exps[i]);
      check_val("len_frames", fd_seen, 1);
    end

    // Overflow: three strobes dropped mid-frame.
    start_capture(64, 0);
    run_frame(2, 20, 3, 1000, 3000);
    check_val("ovf_writes", wr_seen, 64);
    check_val("ovf_flag", 32'(Overflow), 1);
    check_val("ovf_drops", 32'(Drop_Cnt), 3);

    // Continuous mode for three frames, back-to-back strobes.
    start_capture(32, 1);
    run_frame(1, 0, 0, 3, 1000);
    check_val("cont_frames", fd_seen, 3);
    check_val("cont_writes", wr_seen, 96);

    // Abort while draining with two bursts outstanding.
    dma_mode = 1;
    start_capture(32, 0);
    k = 0;
    while (!(m_mode == 2 && m_outs == 2) && k < 600) begin
      Acq_Valid = 1'b1;
      FIFO_Full = (k < 2);
      step();
      k++;
    end
    Acq_Valid = 0; FIFO_Full = 0;
    check_val("abort_reach_flush", 32'(k < 600), 1);
    Abort = 1'b1;
    step();
    check_val("abort_busy", 32'(Busy), 0);
    check_val("abort_req", 32'(Burst_Req), 0);
    check_val("abort_ovf_held", 32'(Overflow), 1);
    check_val("abort_drop_held", 32'(Drop_Cnt), 2);
    dma_mode = 2;
    repeat (2) begin
      Burst_Done = 1'b1;
      step();
    end
    check_val("abort_no_fd", fd_seen, 0);
    check_val("abort_still_idle", 32'(Busy), 0);
    dma_mode = 0;
    start_capture(16, 0);
    run_frame(1, 0, 0, 1000, 1000);
    check_val("post_abort_writes", wr_seen, 16);
    check_val("post_abort_frames", fd_seen, 1);

    // Start and Abort together in IDLE.
    Frame_Len = 16'd32; Start = 1'b1; Abort = 1'b1;
    step();
    check_val("start_abort_busy", 32'(Busy), 0);
    repeat (3) begin
      Acq_Valid = 1'b1;
      step();
    end
    Acq_Valid = 1'b0;

    // Ack coinciding with the write that completes the second burst.
    dma_mode = 2;
    start_capture(48, 0);
    k = 0;
    while (wr_seen < 32 && k < 200) begin
      Acq_Valid = 1'b1;
      step();
      k++;
    end
    Acq_Valid = 1'b0;
    check_val("same_cycle_reach", wr_seen, 32);
    Burst_Ack = 1'b1;
    step();
    check_val("same_cycle_req", 32'(Burst_Req), 1);
    Burst_Ack = 1'b1;
    step();
    check_val("after_ack_req", 32'(Burst_Req), 0);
    dma_mode = 0;
    run_frame(1, 0, 0, 1000, 2000);
    check_val("same_cycle_writes", wr_seen, 48);
    check_val("same_cycle_frames", fd_seen, 1);

    // Asynchronous reset in the middle of a frame.
    start_capture(64, 0);
    repeat (20) begin
      Acq_Valid = 1'b1;
      step();
    end
    Rst = 1'b1;
    #1;
    model_reset();
    compare();
    check_val("midrst_busy", 32'(Busy), 0);
    check_val("midrst_din", 32'(FIFO_Din), 0);
    Rst = 1'b0;
    fd_seen = 0;
    repeat (10) step();
    Acq_Valid = 1'b0;
    check_val("midrst_no_fd", fd_seen, 0);

    // Random soak with free-running DMA, aborts, re-arms and FIFO back-pressure.
    dma_mode = 3;
    for (int c = 0; c < 4000; c++) begin
      Acq_Valid = ($urandom_range(0, 1) == 1);
      FIFO_Full = ($urandom_range(0, 4) == 0);
      Start     = ($urandom_range(0, 15) == 0);
      Abort     = ($urandom_range(0, 150) == 0);
      if ($urandom_range(0, 50) == 0) Continuous = !Continuous;
      Frame_Len = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 40))
                                              : 16'($urandom_range(16, 100));
      step();
      if (c == 2000) begin
        Rst = 1'b1;
        #1;
        model_reset();
        compare();
        Rst = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_capture_sequencer.md
# adc_capture_sequencer

Frame-level sequencer for the ADC-to-DDR acquisition path. It sits between the sample-rate divider, which issues one-cycle `Acq_Valid` strobes, and the sample FIFO / DDR burst writer. It gates samples into the FIFO for exactly one frame, requests one DDR burst per `BURST_LEN` words written, and waits for all bursts to complete before signalling frame done. It supports single-shot and continuous capture, abort, and overflow accounting.

## Interface
- `DATA_WIDTH`, 12: ADC sample width.
- `NUMBER_SAMPLES`, 1024: frame length used when `Frame_Len` is 0.
- `BURST_LEN`, 16: words per DDR burst; power of 2, ≥ 2.
- `Clk` in 1: single clock; all logic is on the rising edge.
- `Rst` in 1: asynchronous, active-high reset.
- `Start` in 1: one-cycle capture start.
- `Abort` in 1: one-cycle abort.
- `Continuous` in 1: re-arm automatically after each frame.
- `Frame_Len` in 16: frame length in samples.
- `Acq_Valid` in 1: decimated sample strobe.
- `ADC_Data` in DATA_WIDTH: sample, valid with `Acq_Valid`.
- `FIFO_Full` in 1: sample FIFO full.
- `FIFO_Wr_En` out 1: FIFO write strobe.
- `FIFO_Din` out DATA_WIDTH: FIFO write data.
- `Burst_Req` out 1: at least one burst is ready for the DMA.
- `Burst_Ack` in 1: one-cycle pulse; the DMA accepted one burst.
- `Burst_Done` in 1: one-cycle pulse; one accepted burst finished in DDR.
- `Busy` out 1: high in any state other than IDLE.
- `Frame_Done` out 1: one-cycle pulse at the end of each frame.
- `Overflow` out 1: sticky; at least one sample was dropped this capture.
- `Drop_Cnt` out 16: samples dropped this capture; saturates at 0xFFFF.
- `Sample_Cnt` out 16: words written in the current frame.

## Operation
- **States:** IDLE, CAPTURE, FLUSH, DONE.
- **Effective length L**, latched on entry to CAPTURE:
  - start from `Frame_Len`, or `NUMBER_SAMPLES` if `Frame_Len` is 0;
  - clear the low log2(`BURST_LEN`) bits;
  - if the result is 0, use `BURST_LEN`.
- **IDLE:**
  - `Start` → CAPTURE.
  - On that transition, clear `Sample_Cnt`, `Overflow`, `Drop_Cnt` and both burst counters.
  - `Acq_Valid` is ignored.
- **CAPTURE:**
  - `Acq_Valid` && !`FIFO_Full`: write the sample and increment `Sample_Cnt`.
  - `Acq_Valid` && `FIFO_Full`: drop the sample, set `Overflow`, increment `Drop_Cnt`. `Sample_Cnt` does not advance.
  - Each time `Sample_Cnt` crosses a multiple of `BURST_LEN`, increment Pending.
  - On the write that makes `Sample_Cnt` equal L → FLUSH. Later `Acq_Valid` strobes are ignored.
- **Burst tracking:**
  - `Burst_Req` = (Pending ≠ 0).
  - `Burst_Ack`: Pending−1 and Outstanding+1.
  - `Burst_Done`: Outstanding−1.
  - Simultaneous increment and decrement on the same counter nets to zero.
  - `Burst_Ack` with Pending = 0, or `Burst_Done` with Outstanding = 0, is ignored (no underflow).
- **FLUSH:** wait until Pending = 0 and Outstanding = 0 → DONE.
- **DONE** (one cycle):
  - `Frame_Done` = 1.
  - If `Continuous` → CAPTURE: re-latch L, clear `Sample_Cnt`; `Overflow`/`Drop_Cnt` are kept.
  - Otherwise → IDLE.
- **`Abort`:**
  - From any state → IDLE on the next edge; highest priority, including over `Start` in the same cycle.
  - Clears Pending, Outstanding and `Sample_Cnt`.
  - No `Frame_Done`. `Overflow` and `Drop_Cnt` are held for software.
- `Start` outside IDLE is ignored.
- `Frame_Len` changes are seen only when L is latched.

## Timing
- **Reset values:** state IDLE; all outputs 0, including `FIFO_Din`, `Sample_Cnt`, `Drop_Cnt`.
- **Write latency:**
  - `FIFO_Wr_En` and `FIFO_Din` are registered.
  - A strobe sampled at edge N gives `FIFO_Wr_En` = 1 during cycle N+1, carrying the `ADC_Data` sampled at edge N.
  - `FIFO_Full` is evaluated at the same edge as `Acq_Valid`.
- **Outputs:**
  - `Burst_Req` is registered; it rises the cycle after the write strobe that completes a burst.
  - `Frame_Done` is high exactly one cycle, the cycle after Outstanding reaches 0.
  - `Busy` is registered from the state.
- **Back-to-back strobes:** `Acq_Valid` on consecutive cycles sustains one write per cycle.
- **Reset mid-frame:** asynchronous return to IDLE; counters cleared; no pulse is emitted.

## Structure
- **Package `adc_acq_pkg`:**
  - state enum type `cap_state_t`;
  - constants `CNT_W` = 16 and `DEF_BURST_LEN` = 16;
  - function computing L from (`Frame_Len`, `NUMBER_SAMPLES`, `BURST_LEN`).
- **Sub-module `acq_burst_tracker`:**
  - holds the Pending and Outstanding counters;
  - inputs: increment, ack, done, clear;
  - outputs: `Burst_Req`, idle.
- The top level holds the FSM, the sample and drop counters, and the FIFO write register.

## Test plan
- **Basic frame:** `Frame_Len` = 64, `BURST_LEN` = 16, `Acq_Valid` every 3 cycles, DMA acks after 2 cycles and completes after 5 → 64 writes, 4 bursts, one `Frame_Done`, `Busy` drops the cycle after.
- **Length rounding:** `Frame_Len` = 0 → L = 1024; `Frame_Len` = 37 → L = 32; `Frame_Len` = 5 → L = 16.
- **Overflow:** hold `FIFO_Full` for 3 strobes mid-frame → `Overflow` = 1, `Drop_Cnt` = 3, still exactly L writes.
- **Continuous mode:** `Continuous` = 1 for 3 frames with back-to-back `Acq_Valid` → 3 `Frame_Done` pulses, each followed by capture with no lost strobe beyond the DONE cycle.
- **Abort:** `Abort` while in FLUSH with Outstanding = 2 → IDLE next cycle, `Burst_Req` = 0, no `Frame_Done`; a late `Burst_Done` is ignored.
- **Same-cycle events:** `Start` with `Abort` in IDLE → stays IDLE. `Burst_Ack` in the same cycle as a burst-completing write → Pending unchanged.
